// File: rtl/mp3_ctrl_pkg.sv
// Shared definitions for the MP3 player control path.
//   - FSM state encoding for the track-change handshake
//   - Command byte values emitted by the Bluetooth decoder
//   - Default sizing for tracks and volume
//   - wrap_track(): reduces a small signed sum into 0..n-1
package mp3_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_REISSUE  = 2'd2
    } state_e;

    // Command bytes understood by the upstream decoder.
    localparam logic [7:0] CMD_B55      = 8'h55;
    localparam logic [7:0] CMD_B5A      = 8'h5A;
    localparam logic [7:0] CMD_BA5      = 8'hA5;
    localparam logic [7:0] CMD_BAA      = 8'hAA;
    localparam logic [7:0] CMD_TRK_BASE = 8'h91;
    localparam logic [7:0] CMD_TRK_LAST = 8'h97;

    localparam int NUM_TRACKS_DEF  = 8;
    localparam int VOL_MAX_DEF     = 15;
    localparam int VOL_DEFAULT_DEF = 8;

    // Inputs are in -7..+14, so eight fold steps cover every legal n (2..8).
    function automatic logic [2:0] wrap_track(input logic signed [4:0] s,
                                              input logic [3:0]        n);
        logic signed [4:0] v;
        logic signed [4:0] ns;
        v  = s;
        ns = $signed({1'b0, n});
        for (int i = 0; i < 8; i++) begin
            if (v < 0)
                v = v + ns;
            else if (v >= ns)
                v = v - ns;
        end
        return v[2:0];
    endfunction

endpackage

// File: rtl/cmd_edge_detect.sv
// Turns the decoder's held-level commands into one-cycle events.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   prev_i, next_i [2:0]  held step counts
//   up_i, down_i          held volume levels
//   track_evt_o           {prev,next} changed to a non-zero value
//   delta_o [3:0]         signed next - prev (-7..+7), valid with track_evt_o
//   up_evt_o, down_evt_o  rising edges of up_i / down_i
module cmd_edge_detect (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        prev_i,
    input  logic [2:0]        next_i,
    input  logic              up_i,
    input  logic              down_i,
    output logic              track_evt_o,
    output logic signed [3:0] delta_o,
    output logic              up_evt_o,
    output logic              down_evt_o
);

    logic [2:0] prev_q, next_q;
    logic       up_q, down_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 3'd0;
            next_q <= 3'd0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            prev_q <= prev_i;
            next_q <= next_i;
            up_q   <= up_i;
            down_q <= down_i;
        end
    end

    // A repeated identical byte without an intervening idle value is
    // deliberately seen as one event.
    assign track_evt_o = ({prev_i, next_i} != {prev_q, next_q}) &&
                         ({prev_i, next_i} != 6'd0);
    assign delta_o     = $signed({1'b0, next_i}) - $signed({1'b0, prev_i});
    assign up_evt_o    = up_i & ~up_q;
    assign down_evt_o  = down_i & ~down_q;

endmodule

// File: rtl/track_volume_ctrl.sv
// Command consumer behind the Bluetooth decoder: keeps the track index and
// volume, and hands track changes to playback over a REQ/ACK handshake.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   PREV, NEXT     held backward/forward step counts
//   UP, DOWN       held volume levels
//   SWITCH_ACK     playback has loaded TRACK
//   TRACK          current track index
//   SWITCH_REQ     track-change request, held until ACK or timeout
//   VOLUME         current volume 0..VOL_MAX
//   VOL_CHANGED    one-cycle pulse when VOLUME changes
//   BUSY           FSM not idle
//   TIMEOUT        one-cycle pulse when a request is abandoned
// Handshake: SWITCH_REQ rises with TRACK already stable; TRACK does not move
// while SWITCH_REQ is high; one cycle with SWITCH_ACK high completes it, and
// SWITCH_ACK is ignored whenever no request is outstanding.
// The FSM register state_q is the observation point for checkers.
module track_volume_ctrl
    import mp3_ctrl_pkg::*;
#(
    parameter int NUM_TRACKS  = NUM_TRACKS_DEF,
    parameter int VOL_MAX     = VOL_MAX_DEF,
    parameter int VOL_DEFAULT = VOL_DEFAULT_DEF,
    parameter int ACK_TIMEOUT = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] PREV,
    input  logic [2:0] NEXT,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       SWITCH_ACK,
    output logic [2:0] TRACK,
    output logic       SWITCH_REQ,
    output logic [3:0] VOLUME,
    output logic       VOL_CHANGED,
    output logic       BUSY,
    output logic       TIMEOUT
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0] NT = 4'(NUM_TRACKS);

    logic              track_evt, up_evt, down_evt;
    logic signed [3:0] delta;

    cmd_edge_detect u_edge (
        .clk_i       (CLK),
        .rst_i       (RST),
        .prev_i      (PREV),
        .next_i      (NEXT),
        .up_i        (UP),
        .down_i      (DOWN),
        .track_evt_o (track_evt),
        .delta_o     (delta),
        .up_evt_o    (up_evt),
        .down_evt_o  (down_evt)
    );

    state_e          state_q, state_d;
    logic [2:0]      track_q, track_d;
    logic            req_q, req_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      vol_q, vol_d;
    logic            vol_chg_q, vol_chg_d;

    logic signed [4:0] delta_x;
    logic [2:0]        target, pend_merged, reissue_track;
    logic              vld_merged;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            track_q    <= 3'd0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 3'd0;
            pend_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
            vol_q      <= 4'(VOL_DEFAULT);
            vol_chg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            track_q    <= track_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            timeout_q  <= timeout_d;
            vol_q      <= vol_d;
            vol_chg_q  <= vol_chg_d;
        end
    end

    // Modular arithmetic on 5-bit signed sums.
    always_comb begin
        delta_x       = {delta[3], delta};
        target        = wrap_track($signed({2'b00, track_q}) + delta_x, NT);
        reissue_track = wrap_track($signed({2'b00, track_q}) + $signed({2'b00, pend_q}), NT);
        // Pending is kept at zero whenever it is not valid, so the merge
        // needs no special case for an empty accumulator.
        pend_merged   = pend_q;
        vld_merged    = pend_vld_q;
        if (track_evt) begin
            pend_merged = wrap_track($signed({2'b00, pend_q}) + delta_x, NT);
            vld_merged  = (pend_merged != 3'd0);
        end
    end

    always_comb begin
        state_d    = state_q;
        track_d    = track_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (track_evt) begin
                    track_d = target;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                cnt_d      = cnt_q + 1'b1;
                pend_d     = pend_merged;
                pend_vld_d = vld_merged;
                // ACK wins over a timeout landing on the same cycle.
                if (SWITCH_ACK) begin
                    req_d   = 1'b0;
                    state_d = vld_merged ? ST_REISSUE : ST_IDLE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    req_d      = 1'b0;
                    timeout_d  = 1'b1;
                    pend_d     = 3'd0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_REISSUE: begin
                track_d    = reissue_track;
                req_d      = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_ACK;
                // Pending restarts empty; a command arriving during this
                // single cycle seeds it rather than being lost.
                pend_d     = 3'd0;
                pend_vld_d = 1'b0;
                if (track_evt) begin
                    pend_d     = wrap_track(delta_x, NT);
                    pend_vld_d = (pend_d != 3'd0);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                req_d      = 1'b0;
                pend_d     = 3'd0;
                pend_vld_d = 1'b0;
            end
        endcase
    end

    // Volume runs independently of the track FSM.
    always_comb begin
        vol_d     = vol_q;
        vol_chg_d = 1'b0;
        if (up_evt && !down_evt && vol_q != 4'(VOL_MAX)) begin
            vol_d     = vol_q + 4'd1;
            vol_chg_d = 1'b1;
        end else if (down_evt && !up_evt && vol_q != 4'd0) begin
            vol_d     = vol_q - 4'd1;
            vol_chg_d = 1'b1;
        end
    end

    assign TRACK       = track_q;
    assign SWITCH_REQ  = req_q;
    assign VOLUME      = vol_q;
    assign VOL_CHANGED = vol_chg_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign TIMEOUT     = timeout_q;

endmodule

// File: doc/track_volume_ctrl.md
Name: track_volume_ctrl

Overview:
- Command-consumer stage directly downstream of the Bluetooth decoder.
- Turns its held-level outputs (PREV/NEXT step counts, UP/DOWN) into one-shot events.
- Maintains the current track index and volume level.
- Hands track changes to the playback/decoder stage through a REQ/ACK handshake, with pending-command merging and an ACK timeout.

Parameters:
- NUM_TRACKS, 8: number of tracks; index wraps modulo NUM_TRACKS; legal range 2..8.
- VOL_MAX, 15: highest volume level.
- VOL_DEFAULT, 8: volume after reset.
- ACK_TIMEOUT, 1000000: CLK cycles to wait for SWITCH_ACK before abandoning a request.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- PREV  in  3  backward step count; held level from the decoder.
- NEXT  in  3  forward step count; held level.
- UP  in  1  volume-up level.
- DOWN  in  1  volume-down level.
- SWITCH_ACK  in  1  playback stage has loaded TRACK.
- TRACK  out  3  current track index.
- SWITCH_REQ  out  1  track-change request; held until ACK or timeout.
- VOLUME  out  4  current volume level, 0..VOL_MAX.
- VOL_CHANGED  out  1  one-cycle pulse when VOLUME changes.
- BUSY  out  1  high in any non-IDLE state.
- TIMEOUT  out  1  one-cycle pulse when a request is abandoned.

Behaviour:
- Reset: all outputs and state clear on a rising CLK edge with RST=1.
  - TRACK=0, VOLUME=VOL_DEFAULT, SWITCH_REQ=0, VOL_CHANGED=0, BUSY=0, TIMEOUT=0.
  - Edge-detect registers are set to zero; pending is cleared; FSM goes to IDLE; the timeout counter is cleared.
  - Reset mid-handshake drops SWITCH_REQ on the same edge; no pulse is emitted.
- Edge detection: a one-deep register holds last cycle's PREV, NEXT, UP and DOWN.
  - Track event: {PREV,NEXT} differs from the stored value and {PREV,NEXT} != 0.
  - Delta = NEXT - PREV, signed, range -7..+7.
  - The same byte sent twice in a row without an intervening default produces no second event; this is accepted.
  - UP event: rising edge of UP. DOWN event: rising edge of DOWN.
- Volume (independent of the FSM):
  - UP event: VOLUME += 1, saturating at VOL_MAX.
  - DOWN event: VOLUME -= 1, saturating at 0.
  - UP and DOWN events in the same cycle cancel: no change, no pulse.
  - VOL_CHANGED pulses only when the value actually changes; no pulse at a saturation limit.
  - Latency: VOLUME and VOL_CHANGED update on the first edge at which the new level is sampled.
- Track arithmetic: target = (TRACK + delta) mod NUM_TRACKS.
  - Computed in 5-bit signed arithmetic.
  - Negative results get NUM_TRACKS added, repeatedly until in range.
- FSM states: IDLE, WAIT_ACK, REISSUE.
  - IDLE:
    - On a track event: TRACK<=target, SWITCH_REQ<=1, clear the counter, go to WAIT_ACK.
    - Latency is 1 edge.
  - WAIT_ACK:
    - The counter increments each cycle.
    - Track events accumulate into a pending delta. Pending is stored mod NUM_TRACKS plus a valid bit; valid clears if the sum is 0 mod NUM_TRACKS.
    - SWITCH_ACK=1: SWITCH_REQ<=0. If pending is valid, go to REISSUE; otherwise go to IDLE.
    - A track event in the same cycle as ACK is folded into pending before that decision.
    - Counter reaches ACK_TIMEOUT-1 without ACK: SWITCH_REQ<=0, TIMEOUT pulses, pending is discarded, go to IDLE. TRACK keeps its last value.
  - REISSUE (one cycle):
    - TRACK<=(TRACK+pending) mod NUM_TRACKS, clear pending, SWITCH_REQ<=1, clear the counter, go to WAIT_ACK.
    - SWITCH_REQ is therefore low for exactly one cycle between consecutive requests.
- SWITCH_ACK arriving in IDLE or REISSUE is ignored.
- TRACK never changes while SWITCH_REQ=1.

Decomposition:
- Shared package (mp3_ctrl_pkg) holds:
  - FSM state encoding.
  - Command byte constants for the decoder: 8'h55, 8'h5A, 8'hA5, 8'hAA, 8'h91..8'h97.
  - VOL_MAX, VOL_DEFAULT and NUM_TRACKS defaults.
- One sub-module, cmd_edge_detect: registers PREV, NEXT, UP and DOWN and emits track_evt, delta, up_evt and down_evt.
- The FSM, volume logic and modular arithmetic stay in the top module.

Test Plan:
- Reset, then NEXT=1 held for 5 cycles -> TRACK=1 after 1 edge, SWITCH_REQ=1 and held; SWITCH_ACK pulse -> SWITCH_REQ=0, BUSY=0; exactly one request.
- From TRACK=0: PREV=3 -> TRACK=5 (wrap with NUM_TRACKS=8). From TRACK=6: NEXT=4 -> TRACK=2.
- During WAIT_ACK (TRACK=1): NEXT=2, then NEXT=0/PREV=0, then NEXT=1; ACK -> REISSUE one cycle with SWITCH_REQ low, then TRACK=4 and SWITCH_REQ=1.
- UP pulsed 10 times from VOLUME=8 -> VOLUME=15, VOL_CHANGED pulses 7 times; UP and DOWN rising together -> no change, no pulse; DOWN x20 -> VOLUME=0.
- Request with no ACK, ACK_TIMEOUT=16 -> SWITCH_REQ drops after 16 cycles, TIMEOUT pulses once, FSM in IDLE, TRACK unchanged.
- RST asserted while SWITCH_REQ=1 with pending valid -> next edge: TRACK=0, VOLUME=8, SWITCH_REQ=0; a later ACK is ignored.
